bsg_sync_read_buffer: RTL

Multi-entry, credit-protected landing buffer for fixed-latency synchronous reads, such as SRAM or tag/data arrays.
- A read is issued with v_n_i, and its data arrives on data_i exactly latency_p cycles later.
- Every return is captured in order and drained through a valid/yumi output. Returned data is never lost under downstream backpressure.
- Sits between a synchronous memory macro and its consumer pipeline, and replaces single-entry hold registers where the consumer may stall.

---
 rtl/bsg_counter_up_down.sv | 31 +++
 rtl/bsg_dff.sv | 26 ++
 rtl/bsg_fifo_1r1w_small.sv | 67 ++++++
 rtl/bsg_sync_read_buffer.sv | 82 ++++++++
 4 files changed

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter holding a count in 0..max_val_p.
// Latency: count_o reflects up_i/down_i one cycle later.
// Backpressure: none; callers must never step past 0 or max_val_p.
module bsg_counter_up_down #(
  parameter int  max_val_p  = 2,
  parameter int  init_val_p = 0,
  localparam int width_lp   = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                up_i,
  input  logic                down_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (up_i && !down_i)      count_d = count_q + width_lp'(1);
    else if (!up_i && down_i) count_d = count_q - width_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) count_q <= width_lp'(init_val_p);
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_dff.sv
// Clocked register with synchronous clear; one stage of a delay line.
// Latency: one cycle from data_i to data_o.
// Backpressure: none, captures every cycle.
module bsg_dff #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_d, data_q;

  always_comb begin
    data_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO, one write and one read port, any depth >= 1.
// Latency: a written entry is visible on data_o/v_o the next cycle.
// Backpressure: writer must not push while full; reader pops with yumi_i.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_d [els_p];
  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [cnt_w_lp-1:0] count_d, count_q;

  // Explicit wrap so non-power-of-two depths cycle through exactly els_p slots.
  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(els_p - 1)) return '0;
    return p + ptr_w_lp'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (v_i) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (yumi_i) rptr_d = ptr_inc(rptr_q);
    if (v_i && !yumi_i)      count_d = count_q + cnt_w_lp'(1);
    else if (!v_i && yumi_i) count_d = count_q - cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign v_o    = (count_q != '0);
  assign data_o = mem_q[rptr_q];

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_i && (count_q == cnt_w_lp'(els_p))));

endmodule

// File: rtl/bsg_sync_read_buffer.sv
// Credit-protected landing buffer for fixed-latency synchronous memory reads.
// Latency: issue to v_o is latency_p+1 cycles, or latency_p with bypass into an empty buffer.
// Backpressure: ready_and_o drops once in-flight plus stored reads reach els_p; yumi_i drains.
module bsg_sync_read_buffer #(
  parameter int width_p   = 8,
  parameter int els_p     = 2,
  parameter int latency_p = 1,
  parameter int bypass_p  = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_n_i,
  output logic               ready_and_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [latency_p:0]  vld_pipe;
  logic                arrive;
  logic [cnt_w_lp-1:0] pending;
  logic                fifo_enq, fifo_deq, fifo_v;
  logic [width_p-1:0]  fifo_data;
  logic                head_v;

  assign vld_pipe[0] = v_n_i;

  for (genvar i = 0; i < latency_p; i++) begin : g_vld
    bsg_dff #(.width_p(1)) vld_dff (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .data_i (vld_pipe[i]),
      .data_o (vld_pipe[i+1])
    );
  end

  assign arrive = vld_pipe[latency_p];

  // Credits are returned only when the consumer takes data, never on arrival.
  bsg_counter_up_down #(.max_val_p(els_p), .init_val_p(0)) credit_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (v_n_i),
    .down_i (yumi_i),
    .count_o(pending)
  );

  bsg_fifo_1r1w_small #(.width_p(width_p), .els_p(els_p)) store (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (fifo_enq),
    .data_i (data_i),
    .v_o    (fifo_v),
    .data_o (fifo_data),
    .yumi_i (fifo_deq)
  );

  always_comb begin
    fifo_enq = arrive;
    fifo_deq = yumi_i;
    head_v   = fifo_v;
    data_o   = fifo_data;
    if (bypass_p != 0) begin
      head_v   = fifo_v | arrive;
      data_o   = fifo_v ? fifo_data : data_i;
      fifo_enq = arrive & (fifo_v | ~yumi_i);
      fifo_deq = yumi_i & fifo_v;
    end
  end

  assign v_o         = ~reset_i & head_v;
  assign ready_and_o = ~reset_i & (pending < cnt_w_lp'(els_p));

  a_issue_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_n_i && !ready_and_o));
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
    !(yumi_i && !v_o));

endmodule
